// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_ctrl
// Description : Register-array instruction memory. It clears to NOP on reset,
//               serves fetches with a valid/ready handshake and has a program mode.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_ctrl #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter int                 DEPTH    = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_inst,
    output logic              resp_err,
    output logic              busy,
    output logic              prog_err
);

    localparam logic [1:0]        S_CLEAR = 2'd0;
    localparam logic [1:0]        S_RUN   = 2'd1;
    localparam logic [1:0]        S_PROG  = 2'd2;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_inst;
    logic              r_resp_err;
    logic              r_prog_err;

    logic              w_pc_ok;
    logic              w_pa_ok;
    logic              w_accept;
    logic              w_clr_we;
    logic              w_prog_we;
    logic [DATA_W-1:0] w_rd_data;

    // Range checks use one extra bit so DEPTH == 2**ADDR_W needs no special case.
    assign w_pc_ok   = {1'b0, req_pc}    < c_depth;
    assign w_pa_ok   = {1'b0, prog_addr} < c_depth;
    assign w_rd_data = r_mem[req_pc];

    assign req_ready = (r_state == S_RUN) && !rst && (!r_resp_valid || resp_ready) && !prog_en;
    assign busy      = rst || (r_state != S_RUN);
    assign w_accept  = req_valid && req_ready;
    assign w_clr_we  = !rst && (r_state == S_CLEAR);
    assign w_prog_we = !rst && (r_state == S_PROG) && prog_we && w_pa_ok;

    assign resp_valid = r_resp_valid;
    assign resp_inst  = r_resp_inst;
    assign resp_err   = r_resp_err;
    assign prog_err   = r_prog_err;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= NOP_WORD;
        end else if (w_prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= NOP_WORD;
            r_resp_err   <= 1'b0;
            r_prog_err   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_resp_valid <= 1'b1;
                        r_resp_inst  <= w_pc_ok ? w_rd_data : NOP_WORD;
                        r_resp_err   <= !w_pc_ok;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                    // A pending response must drain before program mode is entered.
                    if (prog_en && !r_resp_valid) begin
                        r_state <= S_PROG;
                    end
                end
                S_PROG: begin
                    if (prog_we && !w_pa_ok) begin
                        r_prog_err <= 1'b1;
                    end
                    if (!prog_en) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_ctrl
// Description : Randomized scoreboard bench for inst_mem_ctrl (DEPTH=20 plus a
//               default-parameter instance for the clear length).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_ctrl;

    localparam int          DEPTH = 20;
    localparam int          DDEF  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, prog_en, prog_we, req_valid, resp_ready;
    logic [4:0]  prog_addr, req_pc;
    logic [31:0] prog_data;
    logic        req_ready, resp_valid, resp_err, busy, prog_err;
    logic [31:0] resp_inst;

    logic        z1 = 1'b0;
    logic [4:0]  z5 = '0;
    logic [31:0] z32 = '0;
    logic        d_req_ready, d_resp_valid, d_resp_err, d_busy, d_prog_err;
    logic [31:0] d_resp_inst;

    always #5 clk = ~clk;

    inst_mem_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .NOP_WORD(NOP)) u_dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .req_valid(req_valid),
        .req_ready(req_ready), .req_pc(req_pc), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
        .busy(busy), .prog_err(prog_err)
    );

    inst_mem_ctrl u_def (
        .clk(clk), .rst(rst), .prog_en(z1), .prog_we(z1),
        .prog_addr(z5), .prog_data(z32), .req_valid(z1),
        .req_ready(d_req_ready), .req_pc(z5), .resp_valid(d_resp_valid),
        .resp_ready(z1), .resp_inst(d_resp_inst), .resp_err(d_resp_err),
        .busy(d_busy), .prog_err(d_prog_err)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model: mode, outstanding response, sticky error and memory image.
    int          m_left, m_dleft;
    bit          m_prog, m_pend, m_perr, was_rst;
    logic [31:0] m_mem [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every taken response and checks hold stability.
    bit          held = 1'b0;
    logic [31:0] h_inst;
    logic        h_err;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (held) begin
                chk("hold_inst", resp_inst, h_inst);
                chk("hold_err", {31'b0, resp_err}, {31'b0, h_err});
            end
            if (resp_ready === 1'b1) begin
                held = 1'b0;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got inst %h with empty scoreboard", resp_inst);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_inst", resp_inst, mon_e.inst);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                end
            end else begin
                held   = 1'b1;
                h_inst = resp_inst;
                h_err  = resp_err;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [4:0] pc, input logic rr,
                       input logic pe, input logic we, input logic [4:0] pa, input logic [31:0] pd);
        bit   exp_busy, exp_rdy, dbusy, acc;
        exp_t e;
        @(posedge clk);
        #1;
        if (was_rst) begin
            q.delete();
            chk("rst_inst", resp_inst, NOP);
            chk("rst_err", {31'b0, resp_err}, 32'd0);
            chk("def_rst_inst", d_resp_inst, 32'd0);
            chk("def_rst_err", {31'b0, d_resp_err}, 32'd0);
        end
        rst = r; req_valid = v; req_pc = pc; resp_ready = rr;
        prog_en = pe; prog_we = we; prog_addr = pa; prog_data = pd;
        #1;
        exp_busy = r || (m_left > 0) || m_prog;
        exp_rdy  = !exp_busy && (!m_pend || rr) && !pe;
        dbusy    = r || (m_dleft > 0);
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_pend});
        chk("prog_err", {31'b0, prog_err}, {31'b0, m_perr});
        chk("def_busy", {31'b0, d_busy}, {31'b0, dbusy});
        chk("def_req_ready", {31'b0, d_req_ready}, {31'b0, !dbusy});
        chk("def_idle", {30'b0, d_resp_valid, d_prog_err}, 32'd0);
        acc = v && exp_rdy;
        if (r) begin
            m_left = DEPTH; m_dleft = DDEF;
            m_prog = 0; m_pend = 0; m_perr = 0;
            foreach (m_mem[i]) m_mem[i] = NOP;
        end else begin
            if (m_dleft > 0) m_dleft--;
            if (m_left > 0) begin
                m_left--;
            end else if (m_prog) begin
                if (we) begin
                    if (pa < DEPTH) m_mem[pa] = pd;
                    else            m_perr = 1;
                end
                if (!pe) m_prog = 0;
            end else begin
                if (pe && !m_pend) m_prog = 1;
                if (acc) begin
                    e.inst = (pc < DEPTH) ? m_mem[pc] : NOP;
                    e.err  = (pc >= DEPTH);
                    q.push_back(e);
                    m_pend = 1;
                end else if (rr) begin
                    m_pend = 0;
                end
            end
        end
        was_rst = r;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, rr, 0, 0, 5'd0, 32'd0);
    endtask

    task automatic fetch(input logic [4:0] pc, input logic rr);
        cyc(0, 1, pc, rr, 0, 0, 5'd0, 32'd0);
    endtask

    task automatic pwrite(input logic [4:0] pa, input logic [31:0] pd);
        cyc(0, 0, 5'd0, 1, 1, 1, pa, pd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit rpe;
        rst = 1; prog_en = 0; prog_we = 0; req_valid = 0; resp_ready = 1;
        prog_addr = '0; req_pc = '0; prog_data = '0;
        repeat (2) @(posedge clk);
        m_left = DEPTH; m_dleft = DDEF; m_prog = 0; m_pend = 0; m_perr = 0;
        foreach (m_mem[i]) m_mem[i] = NOP;
        was_rst = 1;

        // Clear period on both instances, then a first fetch.
        cyc(1, 0, 5'd0, 1, 0, 0, 5'd0, 32'd0);
        idle(DDEF + 2, 1);
        fetch(5'd7, 1);
        idle(2, 1);

        // Program address 8 (stray write before entry), return, fetch it.
        cyc(0, 0, 5'd0, 1, 0, 1, 5'd9, 32'hDEAD_BEEF);
        cyc(0, 0, 5'd0, 1, 1, 0, 5'd0, 32'd0);
        pwrite(5'd8, 32'h8C08_0002);
        cyc(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'd0);
        fetch(5'd8, 1);
        fetch(5'd9, 1);
        idle(1, 1);

        // Out-of-range fetch and program write, with boundary addresses.
        fetch(5'd25, 1);
        fetch(5'd19, 1);
        fetch(5'd20, 1);
        cyc(0, 0, 5'd0, 1, 1, 0, 5'd0, 32'd0);
        pwrite(5'd21, 32'hFFFF_FFFF);
        pwrite(5'd19, 32'h0BAD_F00D);
        cyc(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'd0);
        fetch(5'd21, 1);
        fetch(5'd1, 1);
        fetch(5'd19, 1);
        idle(1, 1);

        // Backpressure for three cycles, then a streamed burst.
        fetch(5'd8, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 5'd1, 0, 0, 0, 5'd0, 32'd0);
        fetch(5'd1, 1);
        fetch(5'd2, 1);
        fetch(5'd3, 1);
        idle(2, 1);

        // prog_en while a response is held; entry waits for the drain.
        fetch(5'd5, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 5'd0, 0, 1, 0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 5'd0, 1, 1, 0, 5'd0, 32'd0);
        pwrite(5'd3, 32'h1234_5678);
        pwrite(5'd30, 32'h0000_0001);
        cyc(1, 0, 5'd0, 1, 1, 0, 5'd0, 32'd0);
        idle(DDEF + 1, 1);
        fetch(5'd3, 1);
        fetch(5'd8, 1);
        idle(1, 1);

        // Randomized traffic including program sessions and occasional resets.
        rpe = 0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 19) == 0) rpe = !rpe;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) != 0),
                rpe,
                ($urandom_range(0, 1) == 0),
                5'($urandom_range(0, 31)),
                32'($urandom));
        end
        idle(4, 1);
        chk("drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
